// File: rtl/rv32i_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle controller.
// ILLEGAL_OP_TRAP_EN adds the S_TRAP state and the illegal_op flag.
package rv32i_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'd51;
  localparam logic [6:0] OP_I      = 7'd19;
  localparam logic [6:0] OP_LOAD   = 7'd3;
  localparam logic [6:0] OP_STORE  = 7'd35;
  localparam logic [6:0] OP_BRANCH = 7'd99;
  localparam logic [6:0] OP_JAL    = 7'd111;
  localparam logic [6:0] OP_JALR   = 7'd103;
  localparam logic [6:0] OP_LUI    = 7'd55;
  localparam logic [6:0] OP_AUIPC  = 7'd23;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_BR  = 2'b01;
  localparam logic [1:0] ALU_FN  = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;
  localparam logic [1:0] RES_IMM    = 2'b11;

  // One spare bit so the trap state fits and stray codes exist to recover from
  localparam int SW = 5;

  typedef enum logic [SW-1:0] {
    S_RESET    = 5'd0,
    S_FETCH    = 5'd1,
    S_DECODE   = 5'd2,
    S_MEMADR   = 5'd3,
    S_MEMREAD  = 5'd4,
    S_MEMWB    = 5'd5,
    S_MEMWRITE = 5'd6,
    S_EXEC_R   = 5'd7,
    S_EXEC_I   = 5'd8,
    S_ALUWB    = 5'd9,
    S_BRANCH   = 5'd10,
    S_JAL      = 5'd11,
    S_JALR     = 5'd12,
    S_JALR_WB  = 5'd13,
    S_LUI      = 5'd14,
`ifdef ILLEGAL_OP_TRAP_EN
    S_AUIPC    = 5'd15,
    S_TRAP     = 5'd16
`else
    S_AUIPC    = 5'd15
`endif
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_req;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [2:0] imm_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
    logic       ld_st_op;
`ifdef ILLEGAL_OP_TRAP_EN
    logic       illegal_op;
`endif
  } ctrl_t;

endpackage

// File: rtl/rv32i_multicycle_ctrl_if.sv
// Controller <-> datapath control bundle.
// ILLEGAL_OP_TRAP_EN adds illegal_op.
interface rv32i_multicycle_ctrl_if;
  logic [6:0] op_code;
  logic       br_taken;
  logic       mem_ready;
  logic       pc_write;
  logic       adr_src;
  logic       mem_req;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic [2:0] imm_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] result_src;
  logic       ld_st_op;
  logic [3:0] state_o;
`ifdef ILLEGAL_OP_TRAP_EN
  logic       illegal_op;
`endif

  modport master (
    input  op_code, br_taken, mem_ready,
`ifdef ILLEGAL_OP_TRAP_EN
    output illegal_op,
`endif
    output pc_write, adr_src, mem_req, mem_write,
    output ir_write, reg_write, imm_src,
    output alu_src_a, alu_src_b, alu_op,
    output result_src, ld_st_op, state_o
  );

  modport slave (
    output op_code, br_taken, mem_ready,
`ifdef ILLEGAL_OP_TRAP_EN
    input  illegal_op,
`endif
    input  pc_write, adr_src, mem_req, mem_write,
    input  ir_write, reg_write, imm_src,
    input  alu_src_a, alu_src_b, alu_op,
    input  result_src, ld_st_op, state_o
  );
endinterface

// File: rtl/rv32i_ctrl_outdec.sv
// State to control-word decoder for the multi-cycle controller.
// ILLEGAL_OP_TRAP_EN adds the S_TRAP word.
module rv32i_ctrl_outdec
  import rv32i_ctrl_pkg::*;
(
  input  state_e     state_i,
  input  logic [6:0] op_code_i,
  input  logic       br_taken_i,
  input  logic       mem_ready_i,
  output ctrl_t      cw_o
);

  always_comb begin
    cw_o = '0;
    unique case (state_i)
      S_RESET: ;
      S_FETCH: begin
        cw_o.mem_req    = 1'b1;
        cw_o.ir_write   = mem_ready_i;
        cw_o.pc_write   = mem_ready_i;
        cw_o.alu_src_a  = SRCA_PC;
        cw_o.alu_src_b  = SRCB_FOUR;
        cw_o.alu_op     = ALU_ADD;
        cw_o.result_src = RES_ALURES;
      end
      S_DECODE: begin
        cw_o.alu_src_a = SRCA_OLDPC;
        cw_o.alu_src_b = SRCB_IMM;
        cw_o.imm_src   = (op_code_i == OP_JAL) ? IMM_J : IMM_B;
      end
      S_MEMADR: begin
        cw_o.alu_src_a = SRCA_RS1;
        cw_o.alu_src_b = SRCB_IMM;
        cw_o.imm_src   = (op_code_i == OP_STORE) ? IMM_S : IMM_I;
        cw_o.ld_st_op  = 1'b1;
      end
      S_MEMREAD: begin
        cw_o.mem_req  = 1'b1;
        cw_o.adr_src  = 1'b1;
        cw_o.ld_st_op = 1'b1;
      end
      S_MEMWB: begin
        cw_o.result_src = RES_RDATA;
        cw_o.reg_write  = 1'b1;
        cw_o.ld_st_op   = 1'b1;
      end
      S_MEMWRITE: begin
        cw_o.mem_req   = 1'b1;
        cw_o.adr_src   = 1'b1;
        cw_o.ld_st_op  = 1'b1;
        cw_o.mem_write = mem_ready_i;
      end
      S_EXEC_R: begin
        cw_o.alu_src_a = SRCA_RS1;
        cw_o.alu_src_b = SRCB_RS2;
        cw_o.alu_op    = ALU_FN;
      end
      S_EXEC_I: begin
        cw_o.alu_src_a = SRCA_RS1;
        cw_o.alu_src_b = SRCB_IMM;
        cw_o.imm_src   = IMM_I;
        cw_o.alu_op    = ALU_FN;
      end
      S_ALUWB: begin
        cw_o.result_src = RES_ALUOUT;
        cw_o.reg_write  = 1'b1;
      end
      S_BRANCH: begin
        cw_o.alu_src_a  = SRCA_RS1;
        cw_o.alu_src_b  = SRCB_RS2;
        cw_o.alu_op     = ALU_BR;
        cw_o.result_src = RES_ALUOUT;
        cw_o.pc_write   = br_taken_i;
      end
      S_JAL: begin
        cw_o.alu_src_a  = SRCA_OLDPC;
        cw_o.alu_src_b  = SRCB_FOUR;
        cw_o.result_src = RES_ALUOUT;
        cw_o.pc_write   = 1'b1;
      end
      S_JALR: begin
        cw_o.alu_src_a  = SRCA_RS1;
        cw_o.alu_src_b  = SRCB_IMM;
        cw_o.imm_src    = IMM_I;
        cw_o.result_src = RES_ALURES;
        cw_o.pc_write   = 1'b1;
      end
      S_JALR_WB: begin
        cw_o.alu_src_a  = SRCA_OLDPC;
        cw_o.alu_src_b  = SRCB_FOUR;
        cw_o.result_src = RES_ALURES;
        cw_o.reg_write  = 1'b1;
      end
      S_LUI: begin
        cw_o.imm_src    = IMM_U;
        cw_o.result_src = RES_IMM;
        cw_o.reg_write  = 1'b1;
      end
      S_AUIPC: begin
        cw_o.alu_src_a = SRCA_OLDPC;
        cw_o.alu_src_b = SRCB_IMM;
        cw_o.imm_src   = IMM_U;
      end
`ifdef ILLEGAL_OP_TRAP_EN
      S_TRAP: cw_o.illegal_op = 1'b1;
`endif
      default: cw_o = '0;
    endcase
  end

endmodule

// File: rtl/rv32i_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: state register, reset hold, next state.
// ILLEGAL_OP_TRAP_EN traps unknown opcodes in S_TRAP until reset.
module rv32i_multicycle_ctrl
  import rv32i_ctrl_pkg::*;
#(
  parameter int RESET_PC_HOLD = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  rv32i_multicycle_ctrl_if.master  bus
);

  localparam logic [3:0] HOLD_LAST = 4'(RESET_PC_HOLD - 1);

  state_e     state_q, state_d, dec_next;
  logic [3:0] hold_q, hold_d;
  ctrl_t      cw;
  logic [6:0] op;

  assign op = bus.op_code;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RESET;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    dec_next = S_FETCH;
    unique case (1'b1)
      (op == OP_LOAD) || (op == OP_STORE): dec_next = S_MEMADR;
      op == OP_R:      dec_next = S_EXEC_R;
      op == OP_I:      dec_next = S_EXEC_I;
      op == OP_BRANCH: dec_next = S_BRANCH;
      op == OP_JAL:    dec_next = S_JAL;
      op == OP_JALR:   dec_next = S_JALR;
      op == OP_LUI:    dec_next = S_LUI;
      op == OP_AUIPC:  dec_next = S_AUIPC;
`ifdef ILLEGAL_OP_TRAP_EN
      default:         dec_next = S_TRAP;
`else
      default:         dec_next = S_FETCH;
`endif
    endcase
  end

  always_comb begin
    state_d = state_q;
    hold_d  = '0;
    unique case (state_q)
      S_RESET: begin
        if (hold_q == HOLD_LAST) state_d = S_FETCH;
        else hold_d = hold_q + 4'd1;
      end
      S_FETCH:    if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE:   state_d = dec_next;
      S_MEMADR: begin
        if (op == OP_LOAD)       state_d = S_MEMREAD;
        else if (op == OP_STORE) state_d = S_MEMWRITE;
        else                     state_d = S_FETCH;
      end
      S_MEMREAD:  if (bus.mem_ready) state_d = S_MEMWB;
      S_MEMWRITE: if (bus.mem_ready) state_d = S_FETCH;
      S_EXEC_R, S_EXEC_I, S_JAL, S_AUIPC:
        state_d = S_ALUWB;
      S_JALR:     state_d = S_JALR_WB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_JALR_WB, S_LUI:
        state_d = S_FETCH;
`ifdef ILLEGAL_OP_TRAP_EN
      S_TRAP:     state_d = S_TRAP;
`endif
      default:    state_d = S_FETCH;
    endcase
  end

  rv32i_ctrl_outdec u_outdec (
    .state_i     (state_q),
    .op_code_i   (bus.op_code),
    .br_taken_i  (bus.br_taken),
    .mem_ready_i (bus.mem_ready),
    .cw_o        (cw)
  );

  assign bus.pc_write   = cw.pc_write;
  assign bus.adr_src    = cw.adr_src;
  assign bus.mem_req    = cw.mem_req;
  assign bus.mem_write  = cw.mem_write;
  assign bus.ir_write   = cw.ir_write;
  assign bus.reg_write  = cw.reg_write;
  assign bus.imm_src    = cw.imm_src;
  assign bus.alu_src_a  = cw.alu_src_a;
  assign bus.alu_src_b  = cw.alu_src_b;
  assign bus.alu_op     = cw.alu_op;
  assign bus.result_src = cw.result_src;
  assign bus.ld_st_op   = cw.ld_st_op;
  assign bus.state_o    = state_q[3:0];
`ifdef ILLEGAL_OP_TRAP_EN
  assign bus.illegal_op = cw.illegal_op;
`endif

endmodule

// File: tb/tb_rv32i_multicycle_ctrl.sv
// Directed bench for rv32i_multicycle_ctrl.
// Build with ILLEGAL_OP_TRAP_EN to exercise the trap path.
module tb_rv32i_multicycle_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  rv32i_multicycle_ctrl_if bus ();

  rv32i_multicycle_ctrl #(.RESET_PC_HOLD(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] outs();
    return {bus.pc_write, bus.adr_src, bus.mem_req,
            bus.mem_write, bus.ir_write, bus.reg_write,
            bus.imm_src, bus.alu_src_a, bus.alu_src_b,
            bus.alu_op, bus.result_src, bus.ld_st_op};
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    bus.op_code   = 7'd51;
    bus.br_taken  = 1'b0;
    bus.mem_ready = 1'b1;
    #2 rst_n = 1'b0;

    // Reset and R-type
    nxt();
    chk("rst_state", 32'(bus.state_o), 0);
    chk("rst_outs", 32'(outs()), 0);
    rst_n = 1'b1;
    #1;
    chk("hold_state", 32'(bus.state_o), 0);
    chk("hold_outs", 32'(outs()), 0);
    nxt();
    chk("r_fetch_st", 32'(bus.state_o), 1);
    chk("r_fetch_irw", 32'(bus.ir_write), 1);
    chk("r_fetch_pcw", 32'(bus.pc_write), 1);
    chk("r_fetch_mreq", 32'(bus.mem_req), 1);
    chk("r_fetch_srcb", 32'(bus.alu_src_b), 2);
    chk("r_fetch_res", 32'(bus.result_src), 2);
    chk("r_fetch_rw", 32'(bus.reg_write), 0);
    nxt();
    chk("r_dec_st", 32'(bus.state_o), 2);
    chk("r_dec_irw", 32'(bus.ir_write), 0);
    chk("r_dec_pcw", 32'(bus.pc_write), 0);
    chk("r_dec_srca", 32'(bus.alu_src_a), 1);
    chk("r_dec_imm", 32'(bus.imm_src), 2);
    nxt();
    chk("r_exec_st", 32'(bus.state_o), 7);
    chk("r_exec_aluop", 32'(bus.alu_op), 2);
    chk("r_exec_rw", 32'(bus.reg_write), 0);
    nxt();
    chk("r_wb_st", 32'(bus.state_o), 9);
    chk("r_wb_rw", 32'(bus.reg_write), 1);
    chk("r_wb_res", 32'(bus.result_src), 0);
    chk("r_wb_pcw", 32'(bus.pc_write), 0);

    // Fetch stall, then load with two wait cycles
    nxt();
    chk("ld_fetch_st", 32'(bus.state_o), 1);
    bus.mem_ready = 1'b0;
    #1;
    chk("stall_irw", 32'(bus.ir_write), 0);
    chk("stall_pcw", 32'(bus.pc_write), 0);
    nxt();
    chk("stall_st", 32'(bus.state_o), 1);
    bus.op_code   = 7'd3;
    bus.mem_ready = 1'b1;
    #1;
    chk("stall_end_irw", 32'(bus.ir_write), 1);
    nxt();
    chk("ld_dec_st", 32'(bus.state_o), 2);
    nxt();
    chk("ld_madr_st", 32'(bus.state_o), 3);
    chk("ld_madr_ldst", 32'(bus.ld_st_op), 1);
    chk("ld_madr_imm", 32'(bus.imm_src), 0);
    chk("ld_madr_srca", 32'(bus.alu_src_a), 2);
    bus.mem_ready = 1'b0;
    nxt();
    chk("ld_rd1_st", 32'(bus.state_o), 4);
    chk("ld_rd1_mreq", 32'(bus.mem_req), 1);
    chk("ld_rd1_adr", 32'(bus.adr_src), 1);
    chk("ld_rd1_rw", 32'(bus.reg_write), 0);
    nxt();
    chk("ld_rd2_st", 32'(bus.state_o), 4);
    nxt();
    chk("ld_rd3_st", 32'(bus.state_o), 4);
    bus.mem_ready = 1'b1;
    nxt();
    chk("ld_wb_st", 32'(bus.state_o), 5);
    chk("ld_wb_rw", 32'(bus.reg_write), 1);
    chk("ld_wb_res", 32'(bus.result_src), 1);
    chk("ld_wb_ldst", 32'(bus.ld_st_op), 1);

    // Store with one wait cycle
    nxt();
    chk("ld_done_st", 32'(bus.state_o), 1);
    bus.op_code = 7'd35;
    nxt();
    chk("st_dec_st", 32'(bus.state_o), 2);
    nxt();
    chk("st_madr_st", 32'(bus.state_o), 3);
    chk("st_madr_imm", 32'(bus.imm_src), 1);
    chk("st_madr_rw", 32'(bus.reg_write), 0);
    bus.mem_ready = 1'b0;
    nxt();
    chk("st_wr_st", 32'(bus.state_o), 6);
    chk("st_wr_mw_wait", 32'(bus.mem_write), 0);
    chk("st_wr_mreq", 32'(bus.mem_req), 1);
    chk("st_wr_rw", 32'(bus.reg_write), 0);
    bus.mem_ready = 1'b1;
    #1;
    chk("st_wr_mw_rdy", 32'(bus.mem_write), 1);
    nxt();
    chk("st_done_st", 32'(bus.state_o), 1);
    chk("st_done_mw", 32'(bus.mem_write), 0);

    // Branch, not taken then taken
    bus.op_code  = 7'd99;
    bus.br_taken = 1'b0;
    nxt();
    chk("br_dec_st", 32'(bus.state_o), 2);
    nxt();
    chk("br_st", 32'(bus.state_o), 10);
    chk("br_nt_pcw", 32'(bus.pc_write), 0);
    chk("br_aluop", 32'(bus.alu_op), 1);
    bus.br_taken = 1'b1;
    #1;
    chk("br_tk_pcw", 32'(bus.pc_write), 1);
    nxt();
    chk("br_done_st", 32'(bus.state_o), 1);

    // LUI
    bus.op_code  = 7'd55;
    bus.br_taken = 1'b0;
    nxt();
    chk("lui_dec_st", 32'(bus.state_o), 2);
    nxt();
    chk("lui_st", 32'(bus.state_o), 14);
    chk("lui_res", 32'(bus.result_src), 3);
    chk("lui_imm", 32'(bus.imm_src), 4);
    chk("lui_rw", 32'(bus.reg_write), 1);
    nxt();
    chk("lui_done_st", 32'(bus.state_o), 1);

    // JALR
    bus.op_code = 7'd103;
    nxt();
    nxt();
    chk("jalr_st", 32'(bus.state_o), 12);
    chk("jalr_pcw", 32'(bus.pc_write), 1);
    chk("jalr_rw", 32'(bus.reg_write), 0);
    nxt();
    chk("jalrwb_st", 32'(bus.state_o), 13);
    chk("jalrwb_rw", 32'(bus.reg_write), 1);
    chk("jalrwb_pcw", 32'(bus.pc_write), 0);
    nxt();
    chk("jalr_done_st", 32'(bus.state_o), 1);

    // JAL
    bus.op_code = 7'd111;
    nxt();
    chk("jal_dec_imm", 32'(bus.imm_src), 3);
    nxt();
    chk("jal_st", 32'(bus.state_o), 11);
    chk("jal_pcw", 32'(bus.pc_write), 1);
    nxt();
    chk("jal_wb_st", 32'(bus.state_o), 9);
    nxt();
    chk("jal_done_st", 32'(bus.state_o), 1);

    // AUIPC
    bus.op_code = 7'd23;
    nxt();
    nxt();
    chk("auipc_st", 32'(bus.state_o), 15);
    chk("auipc_imm", 32'(bus.imm_src), 4);
    chk("auipc_srca", 32'(bus.alu_src_a), 1);
    nxt();
    chk("auipc_wb_st", 32'(bus.state_o), 9);
    nxt();

    // I-type
    bus.op_code = 7'd19;
    nxt();
    nxt();
    chk("i_st", 32'(bus.state_o), 8);
    chk("i_imm", 32'(bus.imm_src), 0);
    chk("i_aluop", 32'(bus.alu_op), 2);
    nxt();
    chk("i_wb_st", 32'(bus.state_o), 9);
    nxt();
    chk("i_done_st", 32'(bus.state_o), 1);

    // Unknown opcode
    bus.op_code = 7'd127;
    nxt();
    chk("bad_dec_st", 32'(bus.state_o), 2);
`ifdef ILLEGAL_OP_TRAP_EN
    nxt();
    chk("trap_ill", 32'(bus.illegal_op), 1);
    chk("trap_outs", 32'(outs()), 0);
    repeat (3) nxt();
    chk("trap_hold", 32'(bus.illegal_op), 1);
    rst_n = 1'b0;
    #1;
    chk("trap_rst_ill", 32'(bus.illegal_op), 0);
    nxt();
    rst_n = 1'b1;
    nxt();
    chk("trap_exit_st", 32'(bus.state_o), 1);
`else
    nxt();
    chk("nop_st", 32'(bus.state_o), 1);
`endif

    // Reset in the middle of a store write
    bus.op_code = 7'd35;
    nxt();
    nxt();
    nxt();
    chk("ab_wr_st", 32'(bus.state_o), 6);
    chk("ab_wr_mw", 32'(bus.mem_write), 1);
    rst_n = 1'b0;
    #1;
    chk("ab_mw", 32'(bus.mem_write), 0);
    chk("ab_st", 32'(bus.state_o), 0);
    chk("ab_outs", 32'(outs()), 0);
    nxt();
    chk("ab_hold_outs", 32'(outs()), 0);
    rst_n = 1'b1;
    nxt();
    chk("ab_restart_st", 32'(bus.state_o), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rv32i_multicycle_ctrl.md
Name: rv32i_multicycle_ctrl

Overview:
Moore-style control FSM that sequences a shared-ALU, shared-memory multi-cycle RV32I datapath.
- Decodes op_code from the instruction register and steps each instruction through fetch, decode, execute, memory and writeback states.
- Drives all datapath mux selects and write enables.
- Stalls on a memory ready handshake.
- Sits between the instruction register / branch-compare unit and the datapath; pairs with the existing ALU decoder, which consumes alu_op.

Parameters:
RESET_PC_HOLD, 1, number of idle cycles in S_RESET after rst_n deasserts before the first fetch (1..15).

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
op_code  in  7  opcode field of the instruction register
br_taken  in  1  branch condition true, from the branch-compare unit
mem_ready  in  1  memory access completes this cycle
pc_write  out  1  PC register load enable
adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut
mem_req  out  1  memory access request
mem_write  out  1  memory write strobe (qualified by mem_ready)
ir_write  out  1  IR and oldPC load enable
reg_write  out  1  register file write enable
imm_src  out  3  immediate format: 000 I, 001 S, 010 B, 011 J, 100 U
alu_src_a  out  2  00 PC, 01 oldPC, 10 rs1
alu_src_b  out  2  00 rs2, 01 imm, 10 constant 4
alu_op  out  2  00 add, 01 branch compare, 10 funct-decoded
result_src  out  2  00 ALUOut, 01 read data, 10 ALUResult, 11 imm
ld_st_op  out  1  load/store size/sign logic active
state_o  out  4  current state encoding, for debug

Behaviour:
- Outputs are a pure function of the state register, plus br_taken and mem_ready qualification where noted.
- Async reset: state <= S_RESET and the hold counter clears.
  - In S_RESET every output is 0 except state_o.
  - After RESET_PC_HOLD cycles with rst_n high, go to S_FETCH.
- S_FETCH:
  - Outputs: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
  - ir_write and pc_write are asserted only while mem_ready=1.
  - Stay in S_FETCH while mem_ready=0; go to S_DECODE when it is 1.
- S_DECODE:
  - Outputs: alu_src_a=01, alu_src_b=01, imm_src=010, alu_op=00 (precomputes the branch target).
  - Next state by opcode:
    - 3 or 35 -> S_MEMADR
    - 51 -> S_EXEC_R
    - 19 -> S_EXEC_I
    - 99 -> S_BRANCH
    - 111 -> S_JAL
    - 103 -> S_JALR
    - 55 -> S_LUI
    - 23 -> S_AUIPC
    - any other opcode -> S_FETCH (NOP)
- S_MEMADR:
  - Outputs: alu_src_a=10, alu_src_b=01, imm_src=000 for opcode 3 / 001 for opcode 35, alu_op=00, ld_st_op=1.
  - Next state: opcode 3 -> S_MEMREAD; opcode 35 -> S_MEMWRITE.
- S_MEMREAD:
  - Outputs: mem_req=1, adr_src=1, ld_st_op=1.
  - Wait for mem_ready, then go to S_MEMWB.
- S_MEMWB:
  - Outputs: result_src=01, reg_write=1, ld_st_op=1.
  - Next state: S_FETCH.
- S_MEMWRITE:
  - Outputs: mem_req=1, adr_src=1, ld_st_op=1; mem_write=1 only while mem_ready=1.
  - Wait for mem_ready, then go to S_FETCH.
- S_EXEC_R: alu_src_a=10, alu_src_b=00, alu_op=10. Next state: S_ALUWB.
- S_EXEC_I: alu_src_a=10, alu_src_b=01, imm_src=000, alu_op=10. Next state: S_ALUWB.
- S_ALUWB: result_src=00, reg_write=1. Next state: S_FETCH.
- S_BRANCH:
  - Outputs: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00; pc_write=br_taken.
  - Next state: S_FETCH.
- S_JAL:
  - Outputs: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1 (PC <= ALUOut target).
  - Next state: S_ALUWB.
  - Note: ALUOut holds the target computed in S_DECODE with imm_src=011; S_DECODE therefore drives imm_src=011 when opcode=111.
- S_JALR:
  - Outputs: alu_src_a=10, alu_src_b=01, imm_src=000, alu_op=00, result_src=10, pc_write=1.
  - Next state: S_JALR_WB.
- S_JALR_WB: alu_src_a=01, alu_src_b=10, result_src=10, reg_write=1 (writes oldPC+4). Next state: S_FETCH.
- S_LUI: imm_src=100, result_src=11, reg_write=1. Next state: S_FETCH.
- S_AUIPC: alu_src_a=01, alu_src_b=01, imm_src=100, alu_op=00. Next state: S_ALUWB.
- Minimum latencies, with no memory wait:
  - LUI 3 cycles
  - branch 3 cycles
  - R-type, I-type, store, AUIPC, JAL, JALR 4 cycles
  - load 5 cycles
  - each extra mem_ready=0 cycle adds one.
- Boundary conditions:
  - Reset asserted mid-instruction aborts immediately; no write enable may glitch high during reset.
  - Unused state encodings recover to S_FETCH.
  - mem_ready high outside memory states is ignored.

Optional Feature:
ILLEGAL_OP_TRAP_EN
- Defined: adds output illegal_op (1 bit) and state S_TRAP.
  - An unknown opcode in S_DECODE goes to S_TRAP.
  - In S_TRAP illegal_op=1 and all write enables are 0.
  - The FSM stays in S_TRAP until reset.
- Undefined: no port, no state; unknown opcodes fall back to S_FETCH.

Decomposition:
- Shared package rv32i_ctrl_pkg holds:
  - opcode constants (OP_R=51, OP_I=19, OP_LOAD=3, OP_STORE=35, OP_BRANCH=99, OP_JAL=111, OP_JALR=103, OP_LUI=55, OP_AUIPC=23)
  - state encoding localparams
  - imm_src, alu_src_a/b and result_src encodings.
- One natural sub-module: rv32i_ctrl_outdec, a combinational state-to-control-word decoder. The top keeps only the state register, hold counter and next-state logic.

Test Plan:
- Reset with RESET_PC_HOLD=1, mem_ready=1, op_code=51 -> S_RESET with all outputs 0; then FETCH, DECODE, EXEC_R, ALUWB; reg_write=1 only in cycle 4, ir_write/pc_write only in cycle 1.
- op_code=3 with mem_ready low for 2 cycles in MEMREAD -> FSM holds in MEMREAD for 3 cycles total; reg_write with result_src=01 in MEMWB; total latency 7 cycles.
- op_code=35 -> mem_write=1 only in the MEMWRITE cycle where mem_ready=1; reg_write never asserted.
- op_code=99 with br_taken=0 and then br_taken=1 -> pc_write=0 and then pc_write=1 in S_BRANCH; 3-cycle instruction.
- op_code=55, then op_code=103 -> LUI: result_src=11, imm_src=100 in cycle 3; JALR: pc_write in S_JALR, reg_write in S_JALR_WB.
- rst_n dropped during S_MEMWRITE -> mem_write, reg_write and pc_write go to 0 immediately; FSM restarts from S_RESET. With ILLEGAL_OP_TRAP_EN, op_code=127 -> illegal_op=1 held until reset.
